// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset vector and the strobe active level
// common to the control logic and every datapath block.
package cpu_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_ADDR = 8'h00;

    typedef logic [DEF_ADDR_W-1:0] pc_addr_t;

    // Control strobes are active-low across the whole CPU.
    localparam logic STB_ACTIVE = 1'b0;

    function automatic logic stb_on(input logic stb);
        return stb == STB_ACTIVE;
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Strobe and status bundle between the control logic (master) and the program counter (slave).
interface program_counter_if import cpu_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              i_pc_cnt;
    logic              i_pc_den;
    logic              i_pc_din;
    logic              i_pc_push;
    logic              i_pc_pop;
    logic [ADDR_W-1:0] o_pc;
    logic              o_pc_of;
    logic              o_stk_full;
    logic              o_stk_empty;
    logic              o_stk_err;

    modport master (
        output i_pc_cnt, i_pc_den, i_pc_din, i_pc_push, i_pc_pop,
        input  o_pc, o_pc_of, o_stk_full, o_stk_empty, o_stk_err
    );

    modport slave (
        input  i_pc_cnt, i_pc_den, i_pc_din, i_pc_push, i_pc_pop,
        output o_pc, o_pc_of, o_stk_full, o_stk_empty, o_stk_err
    );
endinterface

// File: rtl/pc_return_stack.sv
// Return-address LIFO for CALL/RET. Requests are active-high; pop has priority over push,
// and a push dropped in favour of a pop is not an error.
module pc_return_stack import cpu_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_pop_taken,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_err
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;

    logic [SP_W-1:0]   sp_reg, sp_next;
    logic              err_reg, err_next;
    logic              do_push;
    logic [ADDR_W-1:0] mem_reg [STACK_DEPTH];
    logic [STACK_DEPTH-1:0] wr_sel;
    logic [SP_W-1:0]   top_sp;

    assign o_empty = (sp_reg == '0);
    assign o_full  = (sp_reg == SP_W'(STACK_DEPTH));
    assign o_err   = err_reg;
    assign top_sp  = sp_reg - SP_W'(1);
    // Only consumed when non-empty, so the wrapped index at sp==0 is harmless.
    assign o_top   = mem_reg[top_sp[IDX_W-1:0]];

    always_comb begin
        sp_next     = sp_reg;
        err_next    = err_reg;
        do_push     = 1'b0;
        o_pop_taken = 1'b0;
        if (i_pop) begin
            if (o_empty) begin
                err_next = 1'b1;
            end else begin
                o_pop_taken = 1'b1;
                sp_next     = sp_reg - SP_W'(1);
            end
        end else if (i_push) begin
            if (o_full) begin
                err_next = 1'b1;
            end else begin
                do_push = 1'b1;
                sp_next = sp_reg + SP_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_push && (sp_reg[IDX_W-1:0] == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= i_push_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            sp_reg  <= sp_next;
            err_reg <= err_next;
        end
    end

endmodule

// File: rtl/program_counter.sv
// 8-bit program counter with bus load/drive, sticky wrap flag and a return-address stack.
// One PC action per edge, priority load > pop > increment; push rides alongside.
module program_counter import cpu_pkg::*; #(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = DEF_RESET_ADDR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    inout  wire  [ADDR_W-1:0] io_data_bus,
    program_counter_if.slave  pc_bus
);
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              of_reg, of_next;
    logic              cnt_act, den_act, din_act, push_act, pop_act;
    logic              stk_pop_req;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_pop_taken;
    logic              stk_full, stk_empty, stk_err;

    assign cnt_act  = stb_on(pc_bus.i_pc_cnt);
    assign den_act  = stb_on(pc_bus.i_pc_den);
    assign din_act  = stb_on(pc_bus.i_pc_din);
    assign push_act = stb_on(pc_bus.i_pc_push);
    assign pop_act  = stb_on(pc_bus.i_pc_pop);

    // A load request owns the PC slot even when ignored, so pop must not fire beside it.
    assign stk_pop_req = pop_act && !din_act;

    assign io_data_bus = den_act ? pc_reg : {ADDR_W{1'bz}};

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push_act),
        .i_pop       (stk_pop_req),
        .i_push_data (pc_reg),
        .o_top       (stk_top),
        .o_pop_taken (stk_pop_taken),
        .o_full      (stk_full),
        .o_empty     (stk_empty),
        .o_err       (stk_err)
    );

    always_comb begin
        pc_next = pc_reg;
        of_next = of_reg;
        if (din_act) begin
            // Loading while we drive the bus would read our own value back; hold instead.
            if (!den_act) begin
                pc_next = io_data_bus;
                of_next = 1'b0;
            end
        end else if (pop_act) begin
            if (stk_pop_taken) begin
                pc_next = stk_top;
            end
        end else if (cnt_act) begin
            pc_next = pc_reg + ADDR_W'(1);
            if (pc_reg == '1) begin
                of_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_reg <= RESET_ADDR;
            of_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            of_reg <= of_next;
        end
    end

    assign pc_bus.o_pc        = pc_reg;
    assign pc_bus.o_pc_of     = of_reg;
    assign pc_bus.o_stk_full  = stk_full;
    assign pc_bus.o_stk_empty = stk_empty;
    assign pc_bus.o_stk_err   = stk_err;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table, hand-written corner sequences and
// randomized strobes checked against a queue-based reference model.
module tb_program_counter;
    import cpu_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    localparam bit [4:0] CNT  = 5'b10000;
    localparam bit [4:0] DEN  = 5'b01000;
    localparam bit [4:0] DIN  = 5'b00100;
    localparam bit [4:0] PUSH = 5'b00010;
    localparam bit [4:0] POP  = 5'b00001;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] tb_val;
    wire  [AW-1:0] data_bus;

    always #5 clk = ~clk;

    program_counter_if #(.ADDR_W(AW)) pc_if ();

    // Bench drives the bus only while the PC is not driving it.
    assign data_bus = (pc_if.i_pc_den != STB_ACTIVE) ? tb_val : {AW{1'bz}};

    program_counter #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (8'h00)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_data_bus (data_bus),
        .pc_bus      (pc_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        bit           rst;
        bit [4:0]     act;
        bit [AW-1:0]  bus;
        bit [AW-1:0]  pc;
        bit           of_f;
        bit           full;
        bit           empty;
        bit           err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int          m_pc;
    bit          m_of;
    bit          m_err;
    bit [AW-1:0] m_stk[$];

    function automatic vec_t mk(string n, bit r, bit [4:0] a, bit [AW-1:0] b,
                                bit [AW-1:0] p, bit o, bit f, bit e, bit er);
        vec_t v;
        v.name = n; v.rst = r; v.act = a; v.bus = b;
        v.pc = p; v.of_f = o; v.full = f; v.empty = e; v.err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit [4:0] a, input bit [AW-1:0] b);
        rst             = r;
        pc_if.i_pc_cnt  = ~a[4];
        pc_if.i_pc_den  = ~a[3];
        pc_if.i_pc_din  = ~a[2];
        pc_if.i_pc_push = ~a[1];
        pc_if.i_pc_pop  = ~a[0];
        tb_val          = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string nm, input bit den_on, input bit [AW-1:0] pc_exp);
        if (den_on) chk({nm, ".bus_drive"}, 32'(data_bus), 32'(pc_exp));
        else        chk({nm, ".bus_release"}, 32'(data_bus), 32'(tb_val));
    endtask

    // Model: one action per edge from load/pop/count rules; stack as a queue.
    task automatic model_step(input bit r, input bit [4:0] a, input bit [AW-1:0] b);
        int  old_pc;
        bit  pop_tried;
        old_pc    = m_pc;
        pop_tried = 1'b0;
        if (r) begin
            m_pc = 0; m_of = 1'b0; m_err = 1'b0; m_stk.delete();
            return;
        end
        if (a[2]) begin
            if (!a[3]) begin
                m_pc = int'(b); m_of = 1'b0;
            end
        end else if (a[0]) begin
            pop_tried = 1'b1;
            if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
            else                  m_err = 1'b1;
        end else if (a[4]) begin
            if (m_pc == 255) m_of = 1'b1;
            m_pc = (m_pc + 1) % 256;
        end
        if (a[1] && !pop_tried) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else                       m_stk.push_back(AW'(old_pc));
        end
    endtask

    initial begin
        drive(1'b1, 5'b0, 8'h00);

        vecs.push_back(mk("reset",         1, 0,          8'h00, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("cnt1",          0, CNT,        8'h00, 8'h01, 0, 0, 1, 0));
        vecs.push_back(mk("cnt2",          0, CNT,        8'h00, 8'h02, 0, 0, 1, 0));
        vecs.push_back(mk("cnt3",          0, CNT,        8'h00, 8'h03, 0, 0, 1, 0));
        vecs.push_back(mk("load_fe",       0, DIN,        8'hFE, 8'hFE, 0, 0, 1, 0));
        vecs.push_back(mk("cnt_ff",        0, CNT,        8'h00, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("cnt_wrap",      0, CNT,        8'h00, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk("load_10_clr",   0, DIN,        8'h10, 8'h10, 0, 0, 1, 0));
        vecs.push_back(mk("drive_only",    0, DEN,        8'h00, 8'h10, 0, 0, 1, 0));
        vecs.push_back(mk("load_selfdrv",  0, DEN|DIN,    8'h00, 8'h10, 0, 0, 1, 0));
        vecs.push_back(mk("load_20",       0, DIN,        8'h20, 8'h20, 0, 0, 1, 0));
        vecs.push_back(mk("call_push_cnt", 0, PUSH|CNT,   8'h00, 8'h21, 0, 0, 0, 0));
        vecs.push_back(mk("call_load_80",  0, DIN,        8'h80, 8'h80, 0, 0, 0, 0));
        vecs.push_back(mk("ret_pop",       0, POP,        8'h00, 8'h20, 0, 0, 1, 0));
        vecs.push_back(mk("push1",         0, PUSH,       8'h00, 8'h20, 0, 0, 0, 0));
        vecs.push_back(mk("push2",         0, PUSH,       8'h00, 8'h20, 0, 0, 0, 0));
        vecs.push_back(mk("push3",         0, PUSH,       8'h00, 8'h20, 0, 0, 0, 0));
        vecs.push_back(mk("push4_full",    0, PUSH,       8'h00, 8'h20, 0, 1, 0, 0));
        vecs.push_back(mk("push5_ovf",     0, PUSH,       8'h00, 8'h20, 0, 1, 0, 1));
        vecs.push_back(mk("reset2",        1, 0,          8'h00, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("pop_underflow", 0, POP,        8'h00, 8'h00, 0, 0, 1, 1));
        vecs.push_back(mk("reset3",        1, 0,          8'h00, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("push_one",      0, PUSH,       8'h00, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk("prio_din",      0, DIN|POP|CNT,8'h33, 8'h33, 0, 0, 0, 0));
        vecs.push_back(mk("burst1",        0, CNT,        8'h00, 8'h34, 0, 0, 0, 0));
        vecs.push_back(mk("burst2",        0, CNT,        8'h00, 8'h35, 0, 0, 0, 0));
        vecs.push_back(mk("reset_burst",   1, CNT,        8'h00, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk("load_ff",       0, DIN,        8'hFF, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("load_beats_wrap",0,DIN|CNT,    8'h05, 8'h05, 0, 0, 1, 0));
        vecs.push_back(mk("push_05",       0, PUSH,       8'h00, 8'h05, 0, 0, 0, 0));
        vecs.push_back(mk("push_pop_same", 0, PUSH|POP,   8'h00, 8'h05, 0, 0, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].act, vecs[i].bus);
            tick();
            $display("vec %0d %s: pc=%02h of=%0b full=%0b empty=%0b err=%0b", i, vecs[i].name,
                     pc_if.o_pc, pc_if.o_pc_of, pc_if.o_stk_full, pc_if.o_stk_empty, pc_if.o_stk_err);
            chk({vecs[i].name, ".pc"},    32'(pc_if.o_pc),        32'(vecs[i].pc));
            chk({vecs[i].name, ".of"},    32'(pc_if.o_pc_of),     32'(vecs[i].of_f));
            chk({vecs[i].name, ".full"},  32'(pc_if.o_stk_full),  32'(vecs[i].full));
            chk({vecs[i].name, ".empty"}, 32'(pc_if.o_stk_empty), 32'(vecs[i].empty));
            chk({vecs[i].name, ".err"},   32'(pc_if.o_stk_err),   32'(vecs[i].err));
            chk_bus(vecs[i].name, vecs[i].act[3], vecs[i].pc);
        end

        // Bus drive is combinational: visible before the edge, new pc visible after it.
        drive(1'b0, DIN, 8'h42);
        tick();
        drive(1'b0, DEN, 8'h00);
        #1;
        chk("same_cycle.bus_drive", 32'(data_bus), 32'h42);
        $display("hand same_cycle: bus=%02h", data_bus);
        drive(1'b0, DEN|CNT, 8'h00);
        #1;
        chk("pre_edge.bus_old_pc", 32'(data_bus), 32'h42);
        tick();
        chk("post_edge.bus_new_pc", 32'(data_bus), 32'h43);
        $display("hand post_edge: bus=%02h pc=%02h", data_bus, pc_if.o_pc);
        drive(1'b0, 5'b0, 8'hA5);
        #1;
        chk("release.bus", 32'(data_bus), 32'hA5);

        // Push held low acts once per edge until the stack overflows.
        drive(1'b1, 5'b0, 8'h00);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, PUSH, 8'h00);
            tick();
            $display("hand held_push %0d: full=%0b err=%0b", k, pc_if.o_stk_full, pc_if.o_stk_err);
            chk($sformatf("held_push%0d.full", k), 32'(pc_if.o_stk_full), 32'(k >= 4));
            chk($sformatf("held_push%0d.err", k),  32'(pc_if.o_stk_err),  32'(k >= 5));
        end

        // Randomized run against the reference model.
        for (int n = 0; n < 1000; n++) begin
            bit          r;
            bit [4:0]    a;
            bit [AW-1:0] b;
            r = (n == 0) || ($urandom_range(0, 99) < 2);
            a = '0;
            a[4] = ($urandom_range(0, 99) < 45);
            a[3] = ($urandom_range(0, 99) < 25);
            a[2] = ($urandom_range(0, 99) < 12);
            a[1] = ($urandom_range(0, 99) < 25);
            a[0] = ($urandom_range(0, 99) < 20);
            b = AW'($urandom);
            drive(r, a, b);
            model_step(r, a, b);
            tick();
            $display("rnd %0d: rst=%0b act=%05b bus_in=%02h pc=%02h model=%02h", n, r, a, b,
                     pc_if.o_pc, m_pc[7:0]);
            chk("rnd.pc",    32'(pc_if.o_pc),        32'(m_pc));
            chk("rnd.of",    32'(pc_if.o_pc_of),     32'(m_of));
            chk("rnd.full",  32'(pc_if.o_stk_full),  32'(m_stk.size() == DEPTH));
            chk("rnd.empty", 32'(pc_if.o_stk_empty), 32'(m_stk.size() == 0));
            chk("rnd.err",   32'(pc_if.o_stk_err),   32'(m_err));
            chk_bus("rnd", a[3], AW'(m_pc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 8-bit program counter for the 8-bit CPU. Directly downstream of the control logic.
- Consumes the active-low strobes o_pc_cnt, o_pc_den and o_pc_din, and returns the wrap flag that control logic samples as i_pc_of.
- Drives the current address onto the shared data bus for MAR capture, and accepts jump targets from the bus.
- Includes a small return-address stack for CALL/RET microcode.

Parameters:
- ADDR_W, 8, width of PC and data bus.
- STACK_DEPTH, 4, number of return-address entries (power of two, 2..16).
- RESET_ADDR, 8'h00, PC value after reset.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- io_data_bus  inout  ADDR_W  shared CPU data bus.
- i_pc_cnt  input  1  active-low: increment PC.
- i_pc_den  input  1  active-low: drive PC onto bus.
- i_pc_din  input  1  active-low: load PC from bus.
- i_pc_push  input  1  active-low: push PC onto return stack.
- i_pc_pop  input  1  active-low: pop return stack into PC.
- o_pc  output  ADDR_W  current PC value (debug/LED).
- o_pc_of  output  1  sticky wrap flag; feeds control logic i_pc_of.
- o_stk_full  output  1  return stack holds STACK_DEPTH entries.
- o_stk_empty  output  1  return stack holds zero entries.
- o_stk_err  output  1  sticky: push while full or pop while empty.

Behaviour:
- Reset: only on the rising i_clk edge with i_rst=1. Takes priority over all strobes.
  - pc=RESET_ADDR, o_pc_of=0, o_stk_err=0, stack pointer=0.
  - o_stk_empty=1, o_stk_full=0.
  - Bus released (high-Z) combinationally whenever i_pc_den=1, including during reset.
- Bus drive:
  - io_data_bus = pc while i_pc_den=0, else 'z. Combinational, zero latency.
  - Bus reflects pc after any same-edge update only from the next cycle.
- PC update per edge, one action only, priority din > pop > cnt. Push combines with cnt (see below).
  - Load: i_pc_din=0 and i_pc_den=1 -> pc<=io_data_bus. Also clears o_pc_of.
  - Load with i_pc_den=0: the load is ignored (self-drive contention); pc holds.
  - Pop: i_pc_pop=0, stack non-empty -> pc<=top entry, sp<=sp-1.
  - Pop while empty: pc holds, sp holds, o_stk_err<=1.
  - Increment: i_pc_cnt=0 -> pc<=pc+1, modulo 2^ADDR_W.
  - Wrap: pc=8'hFF and increment -> pc<=8'h00, o_pc_of<=1.
- o_pc_of:
  - Sticky. Cleared only by reset or by a bus load.
  - An increment that wraps on the same edge as a load is suppressed (load wins), so the flag is cleared.
- Push: i_pc_push=0 stores the current pc (pre-increment), then sp<=sp+1.
  - May coincide with i_pc_cnt, so CALL microcode can push the return address and advance in one cycle.
  - Push while full: no store, sp holds, o_stk_err<=1.
  - Push and pop on the same edge: pop is taken (priority). The push is dropped and not flagged.
  - Push on the same edge as a din load: both occur; the stored value is the old pc.
- Flags: o_stk_full=(sp==STACK_DEPTH), o_stk_empty=(sp==0). Registered state, combinational decode.
- o_stk_err: sticky until reset.
- sp width: $clog2(STACK_DEPTH)+1.
- Stack storage: register array, no reset required on entries. Entries are never read while empty.
- All strobes held low for multiple cycles act once per edge (level-sensitive, not edge-detected).

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W default, RESET_ADDR.
  - Typedef pc_addr_t = logic [ADDR_W-1:0].
  - Strobe active level constant STB_ACTIVE=1'b0, used by control logic and all datapath blocks.
- One natural sub-module: pc_return_stack.
  - LIFO with push/pop/full/empty/err.
  - Instantiated once in program_counter.
  - Counter and bus tri-state stay in the top.

Test Plan:
1. Reset, then i_pc_cnt=0 for 3 cycles -> o_pc=8'h03, o_pc_of=0, o_stk_empty=1.
2. Load: bus=8'hFE, i_pc_din=0 for 1 cycle, then i_pc_cnt=0 for 2 cycles -> o_pc=8'h00, o_pc_of=1. Then load 8'h10 -> o_pc_of=0, o_pc=8'h10.
3. Drive: pc=8'h10, i_pc_den=0 -> io_data_bus=8'h10 same cycle. i_pc_den=1 -> bus high-Z. i_pc_den=0 with i_pc_din=0 -> pc stays 8'h10.
4. CALL/RET: pc=8'h20, push+cnt on the same edge, then load 8'h80 -> pc=8'h80, stack top=8'h20. Pop -> pc=8'h20, o_stk_empty=1.
5. Overflow and underflow: 5 pushes with depth 4 -> o_stk_full=1 after the 4th, o_stk_err=1 after the 5th, sp=4. Reset. Pop on an empty stack -> o_stk_err=1, pc unchanged.
6. Priority and reset: din+pop+cnt on one edge with bus=8'h33 -> pc=8'h33, sp unchanged. Assert i_rst mid-increment burst -> next edge pc=8'h00, all flags cleared.
